// File: rtl/rtc_time_reader.sv
// Polls seconds/minutes/hours from an external RTC over a multiplexed AD bus and
// publishes them as one atomic, range-checked BCD snapshot.
module rtc_time_reader #(
   parameter int         PHASE_CYC = 4,
   parameter int         POLL_CYC  = 1000000,
   parameter logic [7:0] ADDR_SEG  = 8'h21,
   parameter logic [7:0] ADDR_MIN  = 8'h22,
   parameter logic [7:0] ADDR_HOR  = 8'h23
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] ad_in,
   output logic [7:0] ad_out,
   output logic       ad_oe,
   output logic       cs_n,
   output logic       rd_n,
   output logic       wr_n,
   output logic       ale,
   output logic [7:0] seg_rtc,
   output logic [7:0] min_rtc,
   output logic [7:0] hora_rtc,
   output logic       valid,
   output logic       err,
   output logic       busy
);

   localparam int PW = $clog2(PHASE_CYC + 1);
   localparam int CW = $clog2(POLL_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_GAP,
      S_DATA,
      S_RECOV,
      S_CHECK
   } state_t;

   state_t          state_reg, state_next;
   logic [PW-1:0]   phase_reg, phase_next;
   logic [CW-1:0]   poll_reg, poll_next;
   logic [1:0]      idx_reg, idx_next;
   logic [7:0]      shadow_reg [3];
   logic            phase_last;
   logic            capture;
   logic            check_pass;

   function automatic logic [7:0] addr_of(input logic [1:0] i);
      case (i)
         2'd0:    return ADDR_SEG;
         2'd1:    return ADDR_MIN;
         default: return ADDR_HOR;
      endcase
   endfunction

   function automatic logic sexa_ok(input logic [7:0] v);
      return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
   endfunction

   function automatic logic hour_ok(input logic [7:0] v);
      return (v[3:0] <= 4'd9) && (v <= 8'h23);
   endfunction

   assign phase_last = (phase_reg == PW'(PHASE_CYC - 1));
   assign capture    = (state_reg == S_DATA) && phase_last;
   assign check_pass = sexa_ok(shadow_reg[0]) && sexa_ok(shadow_reg[1]) && hour_ok(shadow_reg[2]);

   // Phase counter restarts (0) on every state change, otherwise counts up.
   always_comb begin
      state_next = state_reg;
      phase_next = '0;
      poll_next  = poll_reg;
      idx_next   = idx_reg;
      case (state_reg)
         S_IDLE: begin
            if (poll_reg == '0 || start) begin
               poll_next  = CW'(POLL_CYC - 1);
               idx_next   = 2'd0;
               state_next = S_ADDR;
            end else begin
               poll_next = poll_reg - CW'(1);
            end
         end
         S_ADDR: begin
            if (phase_last) state_next = S_GAP;
            else            phase_next = phase_reg + PW'(1);
         end
         S_GAP: begin
            if (phase_last) state_next = S_DATA;
            else            phase_next = phase_reg + PW'(1);
         end
         S_DATA: begin
            if (phase_last) state_next = S_RECOV;
            else            phase_next = phase_reg + PW'(1);
         end
         S_RECOV: begin
            if (phase_last) begin
               if (idx_reg == 2'd2) begin
                  state_next = S_CHECK;
               end else begin
                  idx_next   = idx_reg + 2'd1;
                  state_next = S_ADDR;
               end
            end else begin
               phase_next = phase_reg + PW'(1);
            end
         end
         S_CHECK: state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= S_IDLE;
         phase_reg <= '0;
         poll_reg  <= '0;
         idx_reg   <= 2'd0;
      end else begin
         state_reg <= state_next;
         phase_reg <= phase_next;
         poll_reg  <= poll_next;
         idx_reg   <= idx_next;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow_reg[0] <= '0;
         shadow_reg[1] <= '0;
         shadow_reg[2] <= '0;
      end else if (capture) begin
         case (idx_reg)
            2'd0:    shadow_reg[0] <= ad_in;
            2'd1:    shadow_reg[1] <= ad_in;
            default: shadow_reg[2] <= ad_in;
         endcase
      end
   end

   // Outputs are decoded from the next state so that they line up with state_reg.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ad_out   <= '0;
         ad_oe    <= 1'b0;
         cs_n     <= 1'b1;
         rd_n     <= 1'b1;
         wr_n     <= 1'b1;
         ale      <= 1'b0;
         seg_rtc  <= '0;
         min_rtc  <= '0;
         hora_rtc <= '0;
         valid    <= 1'b0;
         err      <= 1'b0;
         busy     <= 1'b0;
      end else begin
         ad_out <= (state_next == S_ADDR) ? addr_of(idx_next) : 8'h00;
         ad_oe  <= (state_next == S_ADDR);
         ale    <= (state_next == S_ADDR);
         wr_n   <= !(state_next == S_ADDR);
         rd_n   <= !(state_next == S_DATA);
         cs_n   <= !((state_next == S_ADDR) || (state_next == S_DATA));
         busy   <= (state_next != S_IDLE);
         valid  <= (state_next == S_CHECK) && check_pass;
         err    <= (state_next == S_CHECK) && !check_pass;
         if ((state_next == S_CHECK) && check_pass) begin
            seg_rtc  <= shadow_reg[0];
            min_rtc  <= shadow_reg[1];
            hora_rtc <= shadow_reg[2];
         end
      end
   end

endmodule

// File: tb/tb_rtc_time_reader.sv
// Bench for rtc_time_reader: two instances (short and long poll) with an RTC bus model
// and a scoreboard of expected snapshots.
module tb_rtc_time_reader;

   localparam int P      = 2;
   localparam int POLL_A = 50;
   localparam int POLL_B = 1000;
   localparam int LAT    = 12 * P;
   localparam int PERIOD = 12 * P + 1 + POLL_A;

   typedef struct {
      logic [7:0] s, m, h;
      bit         ok;
      logic [7:0] es, em, eh;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Instance A
   logic       reset_a, start_a;
   logic [7:0] ad_in_a, ad_out_a, seg_a, min_a, hor_a;
   logic       ad_oe_a, cs_n_a, rd_n_a, wr_n_a, ale_a, valid_a, err_a, busy_a;
   logic [7:0] mseg_a = 8'h00, mmin_a = 8'h00, mhor_a = 8'h00;
   logic [7:0] addr_a = 8'h00;

   // Instance B
   logic       reset_b, start_b;
   logic [7:0] ad_in_b, ad_out_b, seg_b, min_b, hor_b;
   logic       ad_oe_b, cs_n_b, rd_n_b, wr_n_b, ale_b, valid_b, err_b, busy_b;
   logic [7:0] addr_b = 8'h00;

   rtc_time_reader #(.PHASE_CYC(P), .POLL_CYC(POLL_A)) dut_a (
      .clk(clk), .reset(reset_a), .start(start_a), .ad_in(ad_in_a), .ad_out(ad_out_a),
      .ad_oe(ad_oe_a), .cs_n(cs_n_a), .rd_n(rd_n_a), .wr_n(wr_n_a), .ale(ale_a),
      .seg_rtc(seg_a), .min_rtc(min_a), .hora_rtc(hor_a), .valid(valid_a), .err(err_a),
      .busy(busy_a));

   rtc_time_reader #(.PHASE_CYC(P), .POLL_CYC(POLL_B)) dut_b (
      .clk(clk), .reset(reset_b), .start(start_b), .ad_in(ad_in_b), .ad_out(ad_out_b),
      .ad_oe(ad_oe_b), .cs_n(cs_n_b), .rd_n(rd_n_b), .wr_n(wr_n_b), .ale(ale_b),
      .seg_rtc(seg_b), .min_rtc(min_b), .hora_rtc(hor_b), .valid(valid_b), .err(err_b),
      .busy(busy_b));

   // RTC bus models: latch the address on a write strobe, return the register on reads
   always @(posedge clk) if (!cs_n_a && !wr_n_a && ale_a) addr_a <= ad_out_a;
   always @(posedge clk) if (!cs_n_b && !wr_n_b && ale_b) addr_b <= ad_out_b;

   always_comb begin
      ad_in_a = 8'hFF;
      case (addr_a)
         8'h21: ad_in_a = mseg_a;
         8'h22: ad_in_a = mmin_a;
         8'h23: ad_in_a = mhor_a;
         default: ad_in_a = 8'hFF;
      endcase
   end

   always_comb begin
      ad_in_b = 8'hFF;
      case (addr_b)
         8'h21: ad_in_b = 8'h12;
         8'h22: ad_in_b = 8'h34;
         8'h23: ad_in_b = 8'h05;
         default: ad_in_b = 8'hFF;
      endcase
   end

   int   n_checks = 0;
   int   n_fail   = 0;
   vec_t sb[$];
   bit   have_start_a = 0;
   int   start_cyc_a  = 0;
   bit   prev_ale_a   = 0;
   int   res_a        = 0;
   bit   prev_ale_b   = 0;
   int   starts_b     = 0;
   int   res_b        = 0;
   bit   last_valid_b = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic handle_result_a();
      vec_t e;
      res_a++;
      chk("valid_err_exclusive", {31'd0, valid_a & err_a}, 32'd0);
      if (sb.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL unexpected_result: valid=%0b err=%0b, expected no result", valid_a, err_a);
      end else begin
         e = sb.pop_front();
         $display("result %s s=%02h m=%02h h=%02h -> valid=%0b err=%0b out=%02h/%02h/%02h",
                  e.ok ? "ok " : "bad", e.s, e.m, e.h, valid_a, err_a, seg_a, min_a, hor_a);
         chk("valid", {31'd0, valid_a}, {31'd0, e.ok});
         chk("err", {31'd0, err_a}, {31'd0, !e.ok});
         chk("seg_rtc", {24'd0, seg_a}, {24'd0, e.es});
         chk("min_rtc", {24'd0, min_a}, {24'd0, e.em});
         chk("hora_rtc", {24'd0, hor_a}, {24'd0, e.eh});
         if (have_start_a) chk("latency", cyc - start_cyc_a, LAT);
      end
   endtask

   // One clock step: sample at the falling edge and run the monitors
   task automatic tick();
      @(negedge clk);
      if (reset_a) begin
         have_start_a = 0;
         prev_ale_a   = 0;
      end else begin
         if (ale_a && !prev_ale_a && ad_out_a == 8'h21) begin
            if (have_start_a) chk("burst_period", cyc - start_cyc_a, PERIOD);
            start_cyc_a  = cyc;
            have_start_a = 1;
         end
         prev_ale_a = ale_a;
         if (valid_a || err_a) handle_result_a();
      end
      if (reset_b) begin
         prev_ale_b = 0;
      end else begin
         if (ale_b && !prev_ale_b && ad_out_b == 8'h21) starts_b++;
         prev_ale_b = ale_b;
         if (valid_b || err_b) begin
            res_b++;
            last_valid_b = valid_b;
         end
      end
   endtask

   task automatic wait_result_a(input int max_cyc);
      int r0 = res_a;
      for (int k = 0; k < max_cyc && res_a == r0; k++) tick();
      if (res_a == r0) chk("result_timeout", 32'd0, 32'd1);
   endtask

   task automatic load_vec(input vec_t v);
      mseg_a = v.s;
      mmin_a = v.m;
      mhor_a = v.h;
      sb.push_back(v);
   endtask

   vec_t tv[12];
   vec_t fresh;

   initial begin
      int s0, r0;
      bit hit;
      reset_a = 1'b1;
      reset_b = 1'b1;
      start_a = 1'b0;
      start_b = 1'b0;

      //           s      m      h      ok  es     em     eh
      tv[0]  = '{8'h59, 8'h59, 8'h23, 1, 8'h59, 8'h59, 8'h23};
      tv[1]  = '{8'h10, 8'h00, 8'h24, 0, 8'h59, 8'h59, 8'h23};
      tv[2]  = '{8'h00, 8'h00, 8'h00, 1, 8'h00, 8'h00, 8'h00};
      tv[3]  = '{8'h5A, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00};
      tv[4]  = '{8'h60, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00};
      tv[5]  = '{8'h12, 8'h34, 8'h19, 1, 8'h12, 8'h34, 8'h19};
      tv[6]  = '{8'h00, 8'h3F, 8'h00, 0, 8'h12, 8'h34, 8'h19};
      tv[7]  = '{8'h00, 8'h60, 8'h00, 0, 8'h12, 8'h34, 8'h19};
      tv[8]  = '{8'h45, 8'h07, 8'h09, 1, 8'h45, 8'h07, 8'h09};
      tv[9]  = '{8'h00, 8'h00, 8'h1A, 0, 8'h45, 8'h07, 8'h09};
      tv[10] = '{8'h30, 8'h30, 8'h20, 1, 8'h30, 8'h30, 8'h20};
      tv[11] = '{8'h00, 8'h00, 8'h30, 0, 8'h30, 8'h30, 8'h20};

      // Reset held: all outputs at reset values
      load_vec(tv[0]);
      repeat (3) tick();
      chk("rst_ad_out", {24'd0, ad_out_a}, 32'h0);
      chk("rst_ad_oe", {31'd0, ad_oe_a}, 32'd0);
      chk("rst_ale", {31'd0, ale_a}, 32'd0);
      chk("rst_cs_n", {31'd0, cs_n_a}, 32'd1);
      chk("rst_rd_n", {31'd0, rd_n_a}, 32'd1);
      chk("rst_wr_n", {31'd0, wr_n_a}, 32'd1);
      chk("rst_busy", {31'd0, busy_a}, 32'd0);
      chk("rst_valid", {31'd0, valid_a}, 32'd0);
      chk("rst_err", {31'd0, err_a}, 32'd0);
      chk("rst_seg", {24'd0, seg_a}, 32'h0);
      chk("rst_min", {24'd0, min_a}, 32'h0);
      chk("rst_hora", {24'd0, hor_a}, 32'h0);

      // First burst starts in the first cycle after release
      reset_a = 1'b0;
      tick();
      chk("first_ale", {31'd0, ale_a}, 32'd1);
      chk("first_wr_n", {31'd0, wr_n_a}, 32'd0);
      chk("first_cs_n", {31'd0, cs_n_a}, 32'd0);
      chk("first_ad_oe", {31'd0, ad_oe_a}, 32'd1);
      chk("first_ad_out", {24'd0, ad_out_a}, 32'h21);
      chk("first_busy", {31'd0, busy_a}, 32'd1);

      // Table of snapshots, one per polled burst
      for (int i = 0; i < 12; i++) begin
         wait_result_a(200);
         if (i + 1 < 12) load_vec(tv[i + 1]);
      end

      // Async reset during the minutes DATA phase
      hit = 0;
      for (int k = 0; k < 200 && !hit; k++) begin
         tick();
         if (addr_a == 8'h22 && !rd_n_a) hit = 1;
      end
      chk("reach_min_data", {31'd0, hit}, 32'd1);
      #1 reset_a = 1'b1;
      #1;
      chk("async_cs_n", {31'd0, cs_n_a}, 32'd1);
      chk("async_rd_n", {31'd0, rd_n_a}, 32'd1);
      chk("async_busy", {31'd0, busy_a}, 32'd0);
      chk("async_seg", {24'd0, seg_a}, 32'h0);
      chk("async_min", {24'd0, min_a}, 32'h0);
      chk("async_hora", {24'd0, hor_a}, 32'h0);
      repeat (3) tick();
      fresh = '{8'h01, 8'h02, 8'h03, 1, 8'h01, 8'h02, 8'h03};
      load_vec(fresh);
      reset_a = 1'b0;
      tick();
      chk("restart_ale", {31'd0, ale_a}, 32'd1);
      chk("restart_ad_out", {24'd0, ad_out_a}, 32'h21);
      wait_result_a(200);
      load_vec(fresh);
      wait_result_a(200);
      reset_a = 1'b1;

      // Long-poll instance: start pulse in IDLE and start while busy
      tick();
      reset_b = 1'b0;
      for (int k = 0; k < 200 && res_b == 0; k++) tick();
      chk("b_first_result", res_b, 1);
      chk("b_first_valid", {31'd0, last_valid_b}, 32'd1);
      chk("b_seg", {24'd0, seg_b}, 32'h12);
      chk("b_min", {24'd0, min_b}, 32'h34);
      chk("b_hora", {24'd0, hor_b}, 32'h05);
      repeat (10) tick();
      chk("b_idle_busy", {31'd0, busy_b}, 32'd0);
      s0 = starts_b;
      r0 = res_b;
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      $display("start pulse in IDLE -> busy=%0b ale=%0b ad_out=%02h", busy_b, ale_b, ad_out_b);
      chk("b_start_busy", {31'd0, busy_b}, 32'd1);
      chk("b_start_ale", {31'd0, ale_b}, 32'd1);
      chk("b_start_ad_out", {24'd0, ad_out_b}, 32'h21);
      repeat (5) tick();
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      $display("start pulse while busy=%0b", busy_b);
      repeat (150) tick();
      chk("b_one_burst_starts", starts_b - s0, 1);
      chk("b_one_burst_results", res_b - r0, 1);
      chk("b_back_idle", {31'd0, busy_b}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
